// File: rtl/fas_pkg.sv
// Shared definitions for the fas_core adder/subtractor: mode encoding and
// the majority helper used by the per-bit cell.
package fas_pkg;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

  typedef enum logic {
    FAS_SUB = MODE_SUB,
    FAS_ADD = MODE_ADD
  } fas_mode_e;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/fas_bit.sv
// One-bit combinational add/subtract cell. In subtract mode the carry chain
// carries a borrow, obtained by inverting the minuend bit into the majority.
module fas_bit
  import fas_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);

  logic a_eff;

  assign a_eff = (a_ns == MODE_ADD) ? a : ~a;
  assign s     = a ^ b ^ cin;
  assign cout  = maj3(a_eff, b, cin);

endmodule

// File: rtl/fas_core.sv
// Registered WIDTH-bit ripple adder/subtractor with carry/borrow in and out.
// Define FAS_OVF_EN to add a registered two's-complement overflow flag (ovf).
module fas_core
  import fas_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             a_ns,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid
`ifdef FAS_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;
  logic             out_valid_reg;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      fas_bit u_bit (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (carry[gi]),
        .a_ns (a_ns),
        .s    (sum_next[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  // Result registers hold their value while idle; only the valid flag drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg         <= '0;
      cout_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        s_reg    <= sum_next;
        cout_reg <= carry[WIDTH];
      end
    end
  end

  assign s         = s_reg;
  assign cout      = cout_reg;
  assign out_valid = out_valid_reg;

`ifdef FAS_OVF_EN
  logic ovf_next;
  logic ovf_reg;

  // Add overflows when like-signed operands give an opposite-signed result;
  // subtract overflows when unlike-signed operands flip the minuend's sign.
  always_comb begin
    ovf_next = 1'b0;
    if (a_ns == MODE_ADD)
      ovf_next = (a[WIDTH-1] == b[WIDTH-1]) && (sum_next[WIDTH-1] != a[WIDTH-1]);
    else
      ovf_next = (a[WIDTH-1] != b[WIDTH-1]) && (sum_next[WIDTH-1] != a[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_reg <= 1'b0;
    else if (in_valid)
      ovf_reg <= ovf_next;
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_fas_core.sv
// Bench for fas_core: a WIDTH=4 and a WIDTH=1 instance share control inputs;
// expected results are queued at drive time and popped when out_valid fires.
module tb_fas_core;
  import fas_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a4, b4;
  logic       a1, b1;
  logic       cin;
  logic       a_ns;
  logic [3:0] s4;
  logic       cout4, out_valid4;
  logic       s1, cout1, out_valid1;
`ifdef FAS_OVF_EN
  logic       ovf4, ovf1;
`endif

  fas_core #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a4),
    .b         (b4),
    .cin       (cin),
    .a_ns      (a_ns),
    .s         (s4),
    .cout      (cout4),
    .out_valid (out_valid4)
`ifdef FAS_OVF_EN
    ,
    .ovf       (ovf4)
`endif
  );

  fas_core #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a1),
    .b         (b1),
    .cin       (cin),
    .a_ns      (a_ns),
    .s         (s1),
    .cout      (cout1),
    .out_valid (out_valid1)
`ifdef FAS_OVF_EN
    ,
    .ovf       (ovf1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s4;
    logic       c4, o4, s1, c1, o1;
  } exp_t;

  typedef struct {
    logic [3:0] a4, b4;
    logic       a1, b1, cin;
    fas_mode_e  mode;
    logic [3:0] s4;
    logic       c4, o4, s1, c1, o1;
  } vec_t;

  exp_t exp_q[$];
  exp_t held;
  int   total = 0;
  int   bad   = 0;
  bit   checking = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Arithmetic reference: integer add/subtract, not a bit-level carry chain.
  task automatic model(input int w, input logic [3:0] a, input logic [3:0] b,
                       input logic ci, input logic mode,
                       output logic [3:0] s, output logic c, output logic o);
    int mask;
    int r;
    mask = (1 << w) - 1;
    if (mode == MODE_ADD) begin
      r = int'(a) + int'(b) + int'(ci);
      c = ((r >> w) & 1) != 0;
    end else begin
      r = int'(a) - int'(b) - int'(ci);
      c = int'(a) < (int'(b) + int'(ci));
    end
    s = 4'(r & mask);
    if (mode == MODE_ADD)
      o = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    else
      o = (a[w-1] != b[w-1]) && (s[w-1] != a[w-1]);
  endtask

  task automatic apply(input logic [3:0] xa4, input logic [3:0] xb4,
                       input logic xa1, input logic xb1, input logic xcin,
                       input logic mode, input exp_t e);
    a4 = xa4; b4 = xb4; a1 = xa1; b1 = xb1; cin = xcin; a_ns = mode;
    in_valid = 1'b1;
    exp_q.push_back(e);
    $display("drive a4=%h b4=%h a1=%b b1=%b cin=%b a_ns=%b -> s4=%h c4=%b s1=%b c1=%b",
             xa4, xb4, xa1, xb1, xcin, mode, e.s4, e.c4, e.s1, e.c1);
  endtask

  task automatic drive_model(input logic [3:0] xa4, input logic [3:0] xb4,
                             input logic xa1, input logic xb1,
                             input logic xcin, input logic mode);
    exp_t       e;
    logic [3:0] s1w;
    model(4, xa4, xb4, xcin, mode, e.s4, e.c4, e.o4);
    model(1, {3'b0, xa1}, {3'b0, xb1}, xcin, mode, s1w, e.c1, e.o1);
    e.s1 = s1w[0];
    apply(xa4, xb4, xa1, xb1, xcin, mode, e);
  endtask

  // Monitor: one edge of latency, held outputs while idle.
  always @(posedge clk) begin
    logic iv;
    logic rs;
    exp_t e;
    iv = in_valid;
    rs = rst;
    #1;
    if (checking && !rs && !rst) begin
      check("valid4", int'(out_valid4), int'(iv));
      check("valid1", int'(out_valid1), int'(iv));
      if (iv) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          held = e;
        end
      end
      check("s4", int'(s4), int'(held.s4));
      check("cout4", int'(cout4), int'(held.c4));
      check("s1", int'(s1), int'(held.s1));
      check("cout1", int'(cout1), int'(held.c1));
`ifdef FAS_OVF_EN
      check("ovf4", int'(ovf4), int'(held.o4));
      check("ovf1", int'(ovf1), int'(held.o1));
`endif
    end
  end

  vec_t vecs[10];

  initial begin
    exp_t e;
    vecs[0] = '{4'h3, 4'h5, 1'b1, 1'b0, 1'b0, FAS_SUB, 4'hE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'h0, 4'h1, 1'b0, 1'b1, 1'b0, FAS_SUB, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{4'h0, 4'h0, 1'b0, 1'b0, 1'b0, FAS_SUB, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{4'h7, 4'h1, 1'b1, 1'b0, 1'b0, FAS_ADD, 4'h8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{4'hF, 4'h1, 1'b1, 1'b1, 1'b0, FAS_ADD, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{4'hF, 4'h0, 1'b1, 1'b1, 1'b1, FAS_ADD, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{4'h8, 4'h1, 1'b0, 1'b0, 1'b1, FAS_SUB, 4'h6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{4'h0, 4'h0, 1'b0, 1'b0, 1'b0, FAS_ADD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{4'h5, 4'h3, 1'b1, 1'b1, 1'b1, FAS_SUB, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{4'hA, 4'h5, 1'b0, 1'b1, 1'b1, FAS_ADD, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    held = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rst = 1'b1; in_valid = 1'b0;
    a4 = '0; b4 = '0; a1 = 1'b0; b1 = 1'b0; cin = 1'b0; a_ns = MODE_ADD;

    #2;
    check("rst_s4", int'(s4), 0);
    check("rst_cout4", int'(cout4), 0);
    check("rst_valid4", int'(out_valid4), 0);
    check("rst_valid1", int'(out_valid1), 0);
    @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;

    // Directed table, back-to-back.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      e = '{vecs[i].s4, vecs[i].c4, vecs[i].o4, vecs[i].s1, vecs[i].c1, vecs[i].o1};
      apply(vecs[i].a4, vecs[i].b4, vecs[i].a1, vecs[i].b1, vecs[i].cin,
            vecs[i].mode, e);
    end

    // Idle with moving operands: outputs must hold.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
      cin = 1'($urandom); a_ns = 1'($urandom);
    end

    // Three consecutive pulses.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_model(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);

    // Asynchronous reset while out_valid is high.
    drive_model(4'h7, 4'h1, 1'b1, 1'b1, 1'b1, MODE_ADD);
    @(posedge clk);
    #3;
    check("pre_rst_valid4", int'(out_valid4), 1);
    check("pre_rst_s4", int'(s4), 9);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("async_rst_s4", int'(s4), 0);
    check("async_rst_cout4", int'(cout4), 0);
    check("async_rst_valid4", int'(out_valid4), 0);
    check("async_rst_s1", int'(s1), 0);
    check("async_rst_cout1", int'(cout1), 0);
    check("async_rst_valid1", int'(out_valid1), 0);
`ifdef FAS_OVF_EN
    check("async_rst_ovf4", int'(ovf4), 0);
`endif
    held = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    @(negedge clk);
    rst = 1'b0;

    // Random streaming with gaps.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) < 7) begin
        drive_model(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom));
      end else begin
        in_valid = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
